verificador_paridade: RTL and testbench

Registered even/odd parity checker for a 5-bit data word plus one parity bit. It flags words whose total parity disagrees with the configured mode and keeps a saturating count of failures. It sits at the receive side of a serial or parallel link, after word assembly and before data consumers.

---
 rtl/verificador_paridade_pkg.sv | 10 +
 rtl/verificador_paridade_gerador.sv | 18 +
 rtl/verificador_paridade.sv | 76 +++++++
 tb/tb_verificador_paridade.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/verificador_paridade_pkg.sv
// Shared constants for the parity checker: parity-mode encodings and the
// default width of the error counter.
// No logic here; the top and the generator import these names.
package verificador_paridade_pkg;

  localparam int PARITY_EVEN   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/verificador_paridade_gerador.sv
// Combinational parity generator: XOR of all bits of the data word.
// Latency: none (pure combinational). Backpressure: not applicable.
// Output is 1 when the word carries an odd number of ones.
module gerador_paridade
  import verificador_paridade_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] word_i,
  output logic         par_o
);

  // Reduction XOR gives the word's own parity.
  always_comb begin
    par_o = ^word_i;
  end

endmodule

// File: rtl/verificador_paridade.sv
// Registered even/odd parity checker for a 5-bit word plus parity bit.
// Latency: 1 clock from sampled inputs to S/s_valid/err_count.
// Backpressure: none; accepts one word per cycle qualified by in_valid.
module verificador_paridade
  import verificador_paridade_pkg::*;
#(
  parameter int ODD_PARITY = PARITY_EVEN,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b1,
  input  logic             b2,
  input  logic             b3,
  input  logic             b4,
  input  logic             b5,
  input  logic             bp,
  input  logic             in_valid,
  input  logic             clr_count,
  output logic             S,
  output logic             s_valid,
  output logic [CNT_W-1:0] err_count
);

  localparam logic             MODE    = (ODD_PARITY != PARITY_EVEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             word_par;
  logic             error;
  logic             s_q, s_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  gerador_paridade #(.W(5)) u_gerador (
    .word_i ({b1, b2, b3, b4, b5}),
    .par_o  (word_par)
  );

  // Total parity against the configured mode; odd mode inverts the sense.
  always_comb begin
    error = word_par ^ bp ^ MODE;
  end

  // Next-state: result/valid follow in_valid, counter clears or saturates.
  always_comb begin
    s_d   = s_q;
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      s_d = error;
    end
    if (clr_count) begin
      cnt_d = '0;
    end else if (in_valid && error && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign S         = s_q;
  assign s_valid   = vld_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_verificador_paridade.sv
// Bench for verificador_paridade: even (8-bit count), odd (8-bit count) and
// even with a 2-bit saturating counter, all driven from the same stimulus.
// Expected outputs come from a behavioural model queued at drive time.
module tb_verificador_paridade;

  logic clk = 1'b0;
  logic rst_n, b1, b2, b3, b4, b5, bp, in_valid, clr_count;
  logic s_e, v_e, s_o, v_o, s_s, v_s;
  logic [7:0] cnt_e, cnt_o;
  logic [1:0] cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic s_e, v_e, s_o, v_o, s_s, v_s;
    int   c_e, c_o, c_s;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  always #5 clk = ~clk;

  verificador_paridade #(.ODD_PARITY(0), .CNT_W(8)) dut_even (
    .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .bp(bp), .in_valid(in_valid), .clr_count(clr_count),
    .S(s_e), .s_valid(v_e), .err_count(cnt_e)
  );

  verificador_paridade #(.ODD_PARITY(1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .bp(bp), .in_valid(in_valid), .clr_count(clr_count),
    .S(s_o), .s_valid(v_o), .err_count(cnt_o)
  );

  verificador_paridade #(.ODD_PARITY(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .bp(bp), .in_valid(in_valid), .clr_count(clr_count),
    .S(s_s), .s_valid(v_s), .err_count(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one channel's next state.
  function automatic void model(input logic err, input logic v, input logic c,
                                input logic r, input int maxc,
                                inout logic s, inout logic sv, inout int cnt);
    if (!r) begin
      s = 1'b0; sv = 1'b0; cnt = 0;
    end else begin
      sv = v;
      if (v) s = err;
      if (c) cnt = 0;
      else if (v && err && cnt < maxc) cnt = cnt + 1;
    end
  endfunction

  // w = {b1,b2,b3,b4,b5,bp}; drives one cycle and checks the result after it.
  task automatic step(input logic [5:0] w, input logic v, input logic c, input logic r);
    exp_t e;
    logic p;
    @(negedge clk);
    {b1, b2, b3, b4, b5, bp} = w;
    in_valid = v; clr_count = c; rst_n = r;
    p = ^w;
    model(p,  v, c, r, 255, m.s_e, m.v_e, m.c_e);
    model(~p, v, c, r, 255, m.s_o, m.v_o, m.c_o);
    model(p,  v, c, r, 3,   m.s_s, m.v_s, m.c_s);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("even_S",   {31'b0, s_e},   {31'b0, e.s_e});
    chk("even_vld", {31'b0, v_e},   {31'b0, e.v_e});
    chk("even_cnt", {24'b0, cnt_e}, e.c_e);
    chk("odd_S",    {31'b0, s_o},   {31'b0, e.s_o});
    chk("odd_vld",  {31'b0, v_o},   {31'b0, e.v_o});
    chk("odd_cnt",  {24'b0, cnt_o}, e.c_o);
    chk("sat_S",    {31'b0, s_s},   {31'b0, e.s_s});
    chk("sat_vld",  {31'b0, v_s},   {31'b0, e.v_s});
    chk("sat_cnt",  {30'b0, cnt_s}, e.c_s);
  endtask

  initial begin
    m = '{default: 0};
    rst_n = 1'b0; in_valid = 1'b0; clr_count = 1'b0;
    {b1, b2, b3, b4, b5, bp} = 6'b0;

    // Reset state.
    step(6'b000000, 1'b0, 1'b0, 1'b0);
    step(6'b000000, 1'b0, 1'b0, 1'b0);
    chk("rst_even_cnt", {24'b0, cnt_e}, 32'd0);
    chk("rst_even_S",   {31'b0, s_e},   32'd0);

    // Exhaustive sweep; spot-check the documented examples.
    for (int i = 0; i < 64; i++) begin
      step(i[5:0], 1'b1, 1'b0, 1'b1);
      if (i == 0)  begin chk("ex_000000_even", {31'b0, s_e}, 32'd0);
                         chk("ex_000000_odd",  {31'b0, s_o}, 32'd1); end
      if (i == 2)  chk("ex_000010_even", {31'b0, s_e}, 32'd1);
      if (i == 6)  chk("ex_000110_even", {31'b0, s_e}, 32'd0);
      if (i == 63) chk("ex_111111_even", {31'b0, s_e}, 32'd0);
    end
    chk("sweep_even_cnt32", {24'b0, cnt_e}, 32'd32);
    chk("sweep_odd_cnt32",  {24'b0, cnt_o}, 32'd32);
    chk("sweep_sat_cnt3",   {30'b0, cnt_s}, 32'd3);

    // Gating with errored word 10000,0: S holds across invalid cycles.
    step(6'b000000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(6'b100000, (i % 2) == 0, 1'b0, 1'b1);
    chk("gate_even_cnt3", {24'b0, cnt_e}, 32'd3);
    chk("gate_S_held",    {31'b0, s_e},   32'd1);
    chk("gate_vld_low",   {31'b0, v_e},   32'd0);

    // Saturation of the 2-bit counter, then clear racing an increment.
    step(6'b000000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(6'b100000, 1'b1, 1'b0, 1'b1);
    chk("sat_after5", {30'b0, cnt_s}, 32'd3);
    step(6'b100000, 1'b1, 1'b1, 1'b1);
    chk("clr_prio_cnt", {30'b0, cnt_s}, 32'd0);
    chk("clr_prio_S",   {31'b0, s_s},   32'd1);

    // Reset mid-stream discards the word at that edge.
    step(6'b100000, 1'b1, 1'b0, 1'b1);
    step(6'b100000, 1'b1, 1'b0, 1'b0);
    chk("midrst_S",   {31'b0, s_e},   32'd0);
    chk("midrst_vld", {31'b0, v_e},   32'd0);
    chk("midrst_cnt", {24'b0, cnt_e}, 32'd0);
    step(6'b000000, 1'b0, 1'b0, 1'b1);
    step(6'b000011, 1'b1, 1'b0, 1'b1);
    chk("post_rst_S",   {31'b0, s_e}, 32'd0);
    chk("post_rst_vld", {31'b0, v_e}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
